// File: rtl/bus_timer.sv
// bus_timer -- memory-mapped countdown timer that drives the CPU interrupt line.
//
// Register window (16 bytes at ADDR_BASE, selected by addr[3:2]):
//   0x0 CTRL   R/W  [0] EN, [2:1] MODE, [3] IM (1 = irq enabled); upper bits read 0
//   0x4 PRESET R/W  reload value copied into COUNT on each LOAD
//   0x8 COUNT  RO   current countdown value
//   0xC        reserved: reads 0, writes ignored
//              (with BUS_TIMER_ACK_REG_EN defined: ACK, reads {31'b0, irq_flag},
//               any write clears irq_flag without touching CTRL/PRESET)
//
// Ports:
//   clk     in   clock
//   reset   in   synchronous, active-high reset
//   addr    in   32-bit byte address from the CPU data port
//   byteen  in   per-byte write enables (write = any bit set while addr hits)
//   wdata   in   store data
//   rdata   out  combinational read data, 0 when addr misses the window
//   irq     out  interrupt request = irq_flag & IM (purely from registers)
//
// Any write hitting CTRL or PRESET acknowledges (clears) irq_flag. A flag set
// on the same edge as an acknowledge wins, and a CPU write to CTRL wins over
// the automatic EN clear of a one-shot expiry.
module bus_timer #(
  parameter logic [31:0] ADDR_BASE = 32'h0000_7F00
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] addr,
  input  logic [3:0]  byteen,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        irq
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    CNT  = 2'd2,
    INT  = 2'd3
  } state_t;

  state_t      state_q, state_d;
  logic [3:0]  ctrl_q, ctrl_d;
  logic [31:0] preset_q, preset_d;
  logic [31:0] count_q, count_d;
  logic        irq_flag_q, irq_flag_d;

  logic        hit;
  logic        wr;
  logic        wr_ctrl;
  logic        wr_preset;
  logic        ack;
  logic [31:0] preset_merged;
  logic [3:0]  ctrl_merged;
  logic        en;
  logic [1:0]  mode;
  logic        im;

  assign en   = ctrl_q[0];
  assign mode = ctrl_q[2:1];
  assign im   = ctrl_q[3];

  assign hit       = (addr & 32'hFFFF_FFF0) == ADDR_BASE;
  assign wr        = hit && (byteen != 4'b0000);
  assign wr_ctrl   = wr && (addr[3:2] == 2'd0);
  assign wr_preset = wr && (addr[3:2] == 2'd1);

`ifdef BUS_TIMER_ACK_REG_EN
  assign ack = wr_ctrl || wr_preset || (wr && (addr[3:2] == 2'd3));
`else
  assign ack = wr_ctrl || wr_preset;
`endif

  // Byte-lane merge of store data into PRESET.
  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_preset_lane
      assign preset_merged[8*gi +: 8] = byteen[gi] ? wdata[8*gi +: 8] : preset_q[8*gi +: 8];
    end
  endgenerate

  // CTRL only implements bits [3:0], which all live in byte lane 0.
  assign ctrl_merged = byteen[0] ? wdata[3:0] : ctrl_q;

  // Next-state logic: FSM, register updates, flag set/clear priorities.
  always_comb begin
    logic flag_set;
    logic flag_clr_pulse;
    logic en_clr;
    state_d        = state_q;
    count_d        = count_q;
    flag_set       = 1'b0;
    flag_clr_pulse = 1'b0;
    en_clr         = 1'b0;

    case (state_q)
      IDLE: begin
        if (en) state_d = LOAD;
      end
      LOAD: begin
        count_d = preset_q;
        state_d = CNT;
      end
      CNT: begin
        if (!en) begin
          state_d = IDLE;
        end else if (count_q == 32'd0) begin
          state_d  = INT;
          flag_set = 1'b1;
        end else begin
          count_d = count_q - 32'd1;
        end
      end
      INT: begin
        state_d = IDLE;
        // MODE 1 auto-reloads (EN stays set) and makes irq a one-cycle pulse;
        // every other mode is one-shot.
        if (mode == 2'd1) flag_clr_pulse = 1'b1;
        else              en_clr         = 1'b1;
      end
      default: state_d = IDLE;
    endcase

    ctrl_d = ctrl_q;
    if (en_clr)  ctrl_d[0] = 1'b0;
    if (wr_ctrl) ctrl_d    = ctrl_merged;

    preset_d = wr_preset ? preset_merged : preset_q;

    irq_flag_d = irq_flag_q;
    if (ack || flag_clr_pulse) irq_flag_d = 1'b0;
    if (flag_set)              irq_flag_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      ctrl_q     <= 4'd0;
      preset_q   <= 32'd0;
      count_q    <= 32'd0;
      irq_flag_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      ctrl_q     <= ctrl_d;
      preset_q   <= preset_d;
      count_q    <= count_d;
      irq_flag_q <= irq_flag_d;
    end
  end

  // Read mux: combinational, ignores byteen.
  always_comb begin
    rdata = 32'd0;
    if (hit) begin
      case (addr[3:2])
        2'd0: rdata = {28'd0, ctrl_q};
        2'd1: rdata = preset_q;
        2'd2: rdata = count_q;
`ifdef BUS_TIMER_ACK_REG_EN
        2'd3: rdata = {31'd0, irq_flag_q};
`else
        2'd3: rdata = 32'd0;
`endif
        default: rdata = 32'd0;
      endcase
    end
  end

  assign irq = irq_flag_q & im;

endmodule

// File: tb/tb_bus_timer.sv
// Self-checking bench for bus_timer. Expected values are pushed onto exp_q
// when stimulus is driven and popped when the corresponding DUT output is
// observed.
module tb_bus_timer;

  localparam logic [31:0] BASE = 32'h0000_7F00;

  logic        clk;
  logic        reset;
  logic [31:0] addr;
  logic [3:0]  byteen;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        irq;

  int n_tests;
  int n_fail;
  logic [31:0] exp_q[$];

  bus_timer #(.ADDR_BASE(BASE)) dut (
    .clk    (clk),
    .reset  (reset),
    .addr   (addr),
    .byteen (byteen),
    .wdata  (wdata),
    .rdata  (rdata),
    .irq    (irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Write lands on the next posedge; rd_during is rdata sampled mid-access.
  task automatic bus_write(input logic [31:0] a, input logic [3:0] be,
                           input logic [31:0] d, output logic [31:0] rd_during);
    @(negedge clk);
    addr   = a;
    byteen = be;
    wdata  = d;
    #1 rd_during = rdata;
    @(posedge clk);
    #1;
    byteen = 4'b0000;
  endtask

  task automatic wr(input logic [31:0] a, input logic [3:0] be, input logic [31:0] d);
    logic [31:0] unused_rd;
    bus_write(a, be, d, unused_rd);
  endtask

  task automatic bus_read(input logic [31:0] a, output logic [31:0] d);
    addr   = a;
    byteen = 4'b0000;
    #1 d = rdata;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset  = 1'b1;
    byteen = 4'b0000;
    tick();
    tick();
    reset = 1'b0;
  endtask

  // Pops the next expectation; an empty queue is itself a failure.
  task automatic pop_exp(output logic [31:0] e);
    if (exp_q.size() == 0) e = 32'hDEAD_BEEF;
    else e = exp_q.pop_front();
  endtask

  task automatic test_reset();
    logic [31:0] rd, e;
    do_reset();
    for (int i = 0; i < 4; i++) begin
      exp_q.push_back(32'd0);
      bus_read(BASE + 32'(4 * i), rd);
      pop_exp(e);
      n_tests++;
      if (rd !== e) begin
        n_fail++;
        $display("FAIL reset_read_off%0d: got %h expected %h", 4 * i, rd, e);
      end
    end
    exp_q.push_back(32'd0);
    pop_exp(e);
    n_tests++;
    if ({31'd0, irq} !== e) begin
      n_fail++;
      $display("FAIL reset_irq: got %b expected %0d", irq, e);
    end
    $display("[TB] test_reset done");
  endtask

  task automatic test_oneshot();
    logic [31:0] rd, e;
    int first;
    do_reset();
    wr(BASE + 4, 4'hF, 32'd5);
    wr(BASE, 4'hF, 32'h9);
    exp_q.push_back(32'd8);             // PRESET + 3 edges after the CTRL write
    first = 0;
    for (int k = 1; k <= 8; k++) begin
      tick();
      if (irq === 1'b1 && first == 0) first = k;
    end
    pop_exp(e);
    n_tests++;
    if (32'(first) !== e) begin
      n_fail++;
      $display("FAIL oneshot_latency: got %0d expected %0d", first, e);
    end
    tick();
    exp_q.push_back(32'h8);             // EN cleared by the one-shot expiry
    bus_read(BASE, rd);
    pop_exp(e);
    n_tests++;
    if (rd !== e) begin
      n_fail++;
      $display("FAIL oneshot_ctrl_en_clear: got %h expected %h", rd, e);
    end
    tick(); tick(); tick();
    exp_q.push_back(32'd1);
    pop_exp(e);
    n_tests++;
    if ({31'd0, irq} !== e) begin
      n_fail++;
      $display("FAIL oneshot_irq_held: got %b expected %0d", irq, e);
    end
    wr(BASE, 4'hF, 32'h8);
    exp_q.push_back(32'd0);
    pop_exp(e);
    n_tests++;
    if ({31'd0, irq} !== e) begin
      n_fail++;
      $display("FAIL oneshot_ack: got %b expected %0d", irq, e);
    end
    $display("[TB] test_oneshot done");
  endtask

  task automatic test_periodic();
    logic [31:0] e;
    int pulses;
    do_reset();
    wr(BASE + 4, 4'hF, 32'd2);
    wr(BASE, 4'hF, 32'hB);
    // First pulse PRESET+3 = 5 edges in, then every PRESET+4 = 6 cycles.
    for (int p = 5; p <= 30; p += 6) exp_q.push_back(32'(p));
    pulses = 0;
    for (int k = 1; k <= 30; k++) begin
      tick();
      if (irq === 1'b1) begin
        pulses++;
        pop_exp(e);
        n_tests++;
        if (32'(k) !== e) begin
          n_fail++;
          $display("FAIL periodic_pulse_edge: got %0d expected %0d", k, e);
        end
      end
    end
    exp_q.delete();
    exp_q.push_back(32'd5);
    pop_exp(e);
    n_tests++;
    if (32'(pulses) !== e) begin
      n_fail++;
      $display("FAIL periodic_pulse_count: got %0d expected %0d", pulses, e);
    end
    $display("[TB] test_periodic done");
  endtask

  task automatic test_masked();
    logic [31:0] rd, e;
    int highs;
    do_reset();
    wr(BASE + 4, 4'hF, 32'd3);
    wr(BASE, 4'hF, 32'h1);
    highs = 0;
    for (int k = 0; k < 10; k++) begin
      tick();
      if (irq !== 1'b0) highs++;
    end
    exp_q.push_back(32'd0);
    pop_exp(e);
    n_tests++;
    if (32'(highs) !== e) begin
      n_fail++;
      $display("FAIL masked_irq_cycles: got %0d expected %0d", highs, e);
    end
    exp_q.push_back(32'h0);
    bus_read(BASE, rd);
    pop_exp(e);
    n_tests++;
    if (rd !== e) begin
      n_fail++;
      $display("FAIL masked_ctrl: got %h expected %h", rd, e);
    end
`ifdef BUS_TIMER_ACK_REG_EN
    exp_q.push_back(32'd1);
`else
    exp_q.push_back(32'd0);
`endif
    bus_read(BASE + 32'hC, rd);
    pop_exp(e);
    n_tests++;
    if (rd !== e) begin
      n_fail++;
      $display("FAIL masked_off_c: got %h expected %h", rd, e);
    end
    wr(BASE, 4'b0001, 32'h8);           // sets IM but is itself an acknowledge
    exp_q.push_back(32'd0);
    pop_exp(e);
    n_tests++;
    if ({31'd0, irq} !== e) begin
      n_fail++;
      $display("FAIL masked_im_write_acks: got %b expected %0d", irq, e);
    end
    exp_q.push_back(32'h8);
    bus_read(BASE, rd);
    pop_exp(e);
    n_tests++;
    if (rd !== e) begin
      n_fail++;
      $display("FAIL masked_ctrl_after: got %h expected %h", rd, e);
    end
    $display("[TB] test_masked done");
  endtask

  task automatic test_coincident();
    logic [31:0] rd, e;
    int first;
    do_reset();
    wr(BASE + 4, 4'hF, 32'd3);
    wr(BASE, 4'hF, 32'h9);              // edge W
    for (int k = 0; k < 5; k++) tick();
    wr(BASE + 4, 4'hF, 32'd3);          // ack on edge W+6, same edge as flag set
    exp_q.push_back(32'd1);
    pop_exp(e);
    n_tests++;
    if ({31'd0, irq} !== e) begin
      n_fail++;
      $display("FAIL set_beats_ack: got %b expected %0d", irq, e);
    end
    wr(BASE, 4'hF, 32'h9);              // W+7: INT EN clear vs CPU write
    exp_q.push_back(32'd0);
    pop_exp(e);
    n_tests++;
    if ({31'd0, irq} !== e) begin
      n_fail++;
      $display("FAIL ctrl_write_ack: got %b expected %0d", irq, e);
    end
    exp_q.push_back(32'h9);
    bus_read(BASE, rd);
    pop_exp(e);
    n_tests++;
    if (rd !== e) begin
      n_fail++;
      $display("FAIL cpu_write_beats_en_clear: got %h expected %h", rd, e);
    end
    exp_q.push_back(32'd6);             // restarted from IDLE with PRESET 3
    first = 0;
    for (int k = 1; k <= 6; k++) begin
      tick();
      if (irq === 1'b1 && first == 0) first = k;
    end
    pop_exp(e);
    n_tests++;
    if (32'(first) !== e) begin
      n_fail++;
      $display("FAIL restart_latency: got %0d expected %0d", first, e);
    end
    $display("[TB] test_coincident done");
  endtask

  task automatic test_midcount_reset();
    logic [31:0] rd, e;
    do_reset();
    wr(BASE + 4, 4'hF, 32'd100);
    wr(BASE, 4'hF, 32'h9);              // edge W
    for (int k = 0; k < 19; k++) tick();
    wr(BASE, 4'hF, 32'h8);              // edge W+20: 18 decrements done
    exp_q.push_back(32'd82);
    bus_read(BASE + 8, rd);
    pop_exp(e);
    n_tests++;
    if (rd !== e) begin
      n_fail++;
      $display("FAIL midcount_value: got %0d expected %0d", rd, e);
    end
    for (int k = 0; k < 5; k++) tick();
    exp_q.push_back(32'd82);
    bus_read(BASE + 8, rd);
    pop_exp(e);
    n_tests++;
    if (rd !== e) begin
      n_fail++;
      $display("FAIL midcount_frozen: got %0d expected %0d", rd, e);
    end
    wr(BASE, 4'hF, 32'h9);
    for (int k = 0; k < 10; k++) tick();
    @(negedge clk);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      exp_q.push_back(32'd0);
      bus_read(BASE + 32'(4 * i), rd);
      pop_exp(e);
      n_tests++;
      if (rd !== e) begin
        n_fail++;
        $display("FAIL midrun_reset_off%0d: got %h expected %h", 4 * i, rd, e);
      end
    end
    exp_q.push_back(32'd0);
    pop_exp(e);
    n_tests++;
    if ({31'd0, irq} !== e) begin
      n_fail++;
      $display("FAIL midrun_reset_irq: got %b expected %0d", irq, e);
    end
    $display("[TB] test_midcount_reset done");
  endtask

  task automatic test_addr_miss();
    logic [31:0] rd, e;
    logic [31:0] miss_addr[2];
    logic [31:0] chk_exp[3];
    do_reset();
    wr(BASE + 4, 4'hF, 32'h0000_1234);
    miss_addr[0] = BASE + 32'h10;
    miss_addr[1] = BASE - 32'h4;
    for (int i = 0; i < 2; i++) begin
      exp_q.push_back(32'd0);
      bus_write(miss_addr[i], 4'hF, 32'hFFFF_FFFF, rd);
      pop_exp(e);
      n_tests++;
      if (rd !== e) begin
        n_fail++;
        $display("FAIL miss_rdata_%h: got %h expected %h", miss_addr[i], rd, e);
      end
    end
    chk_exp[0] = 32'h0;
    chk_exp[1] = 32'h0000_1234;
    chk_exp[2] = 32'h0;
    for (int i = 0; i < 3; i++) begin
      exp_q.push_back(chk_exp[i]);
      bus_read(BASE + 32'(4 * i), rd);
      pop_exp(e);
      n_tests++;
      if (rd !== e) begin
        n_fail++;
        $display("FAIL miss_unchanged_off%0d: got %h expected %h", 4 * i, rd, e);
      end
    end
    wr(BASE + 4, 4'b0101, 32'hAABB_CCDD);
    exp_q.push_back(32'h00BB_12DD);
    bus_read(BASE + 4, rd);
    pop_exp(e);
    n_tests++;
    if (rd !== e) begin
      n_fail++;
      $display("FAIL preset_byte_merge: got %h expected %h", rd, e);
    end
    wr(BASE, 4'hF, 32'hFFFF_FFF0);
    exp_q.push_back(32'h0);
    bus_read(BASE, rd);
    pop_exp(e);
    n_tests++;
    if (rd !== e) begin
      n_fail++;
      $display("FAIL ctrl_upper_bits: got %h expected %h", rd, e);
    end
    $display("[TB] test_addr_miss done");
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    reset   = 1'b1;
    addr    = 32'd0;
    byteen  = 4'b0000;
    wdata   = 32'd0;
    test_reset();
    test_oneshot();
    test_periodic();
    test_masked();
    test_coincident();
    test_midcount_reset();
    test_addr_miss();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
